alu_cmd_sequencer: RTL

//  Upstream front-end of the sequential ALU. Accepts one command {op, A, B} on a valid/ready port and

---
 rtl/alu_pkg.sv | 41 ++++
 rtl/alu_seq_timeout.sv | 47 ++++
 rtl/alu_cmd_sequencer.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// +----------------------------------------------------------------------------+
// | Module      : alu_pkg                                                      |
// | Description : Shared definitions for the sequential-ALU command front-end: |
// |               op codes, sequencer FSM state encoding and a helper that     |
// |               gives the number of result words each op returns.            |
// | Ports       : none (package)                                               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

package alu_pkg;

  localparam logic [1:0] ALU_OP_ADD = 2'b00;
  localparam logic [1:0] ALU_OP_SUB = 2'b01;
  localparam logic [1:0] ALU_OP_MUL = 2'b10;
  localparam logic [1:0] ALU_OP_DIV = 2'b11;

  // Sequencer states, explicitly encoded in 3 bits.
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ISSUE    = 3'd1,
    ST_LOAD_A   = 3'd2,
    ST_LOAD_B   = 3'd3,
    ST_WAIT_END = 3'd4,
    ST_CAP_HI   = 3'd5,
    ST_RESP     = 3'd6
  } seq_state_t;

  // Add/sub produce a single result word; mul/div produce two (lo then hi).
  function automatic logic [1:0] alu_op_words(input logic [1:0] op);
    logic [1:0] words;
    words = 2'd1;
    if ((op == ALU_OP_MUL) || (op == ALU_OP_DIV)) begin
      words = 2'd2;
    end
    return words;
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_seq_timeout.sv
// +----------------------------------------------------------------------------+
// | Module      : alu_seq_timeout                                              |
// | Description : Saturating cycle counter with clear, enable and expire.      |
// |               Only compiled when ALU_SEQ_TIMEOUT_EN is defined.            |
// | Ports       : clk     - clock, rising edge                                 |
// |               reset   - synchronous, active-low reset                      |
// |               clear   - zero the count (wins over enable)                  |
// |               enable  - count one cycle                                    |
// |               expire  - high in the LIMIT-th enabled cycle since clear     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

`ifdef ALU_SEQ_TIMEOUT_EN
module alu_seq_timeout #(
  parameter int LIMIT = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CNT_W = $clog2(LIMIT + 1);
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(LIMIT - 1);
  localparam logic [CNT_W-1:0] C_SAT  = CNT_W'(LIMIT);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (enable && (r_count != C_SAT)) begin
      r_count <= r_count + 1'b1;
    end
  end

  // The count lags the enabled cycle by one, so LIMIT-1 marks the LIMIT-th cycle.
  assign expire = enable && (r_count == C_LAST);

endmodule
`endif

`default_nettype wire

// File: rtl/alu_cmd_sequencer.sv
// +----------------------------------------------------------------------------+
// | Module      : alu_cmd_sequencer                                            |
// | Description : Front-end for the sequential ALU. Takes one {op,A,B} command |
// |               on a valid/ready port, drives the ALU serial protocol        |
// |               (BEGIN, op_code, inbus), collects the result word(s) from    |
// |               outbus after END and returns them on a valid/ready response  |
// |               port. One command in flight at a time.                       |
// | Options     : ALU_SEQ_TIMEOUT_EN - adds timeout_err and a WAIT_END abort   |
// |               after TIMEOUT_CYCLES cycles without END.                     |
// | Ports       : clk, reset (sync, active-low)                                |
// |               cmd_valid/cmd_ready/cmd_op/cmd_a/cmd_b   - command in        |
// |               rsp_valid/rsp_ready/rsp_op/rsp_data      - response out      |
// |               alu_begin/alu_op_code/alu_inbus          - to ALU            |
// |               alu_outbus/alu_end                       - from ALU          |
// |               busy                                     - not IDLE          |
// |               timeout_err (option only)                - aborted response  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int DATA_W         = 8,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_op,
  input  logic [DATA_W-1:0]   cmd_a,
  input  logic [DATA_W-1:0]   cmd_b,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [1:0]          rsp_op,
  output logic [2*DATA_W-1:0] rsp_data,
  output logic                alu_begin,
  output logic [1:0]          alu_op_code,
  output logic [DATA_W-1:0]   alu_inbus,
  input  logic [DATA_W-1:0]   alu_outbus,
  input  logic                alu_end,
  output logic                busy
`ifdef ALU_SEQ_TIMEOUT_EN
  ,
  output logic                timeout_err
`endif
);

  seq_state_t          r_state;
  logic [1:0]          r_op;
  logic [DATA_W-1:0]   r_a;
  logic [DATA_W-1:0]   r_b;
  logic                r_cmd_ready;
  logic                r_rsp_valid;
  logic [1:0]          r_rsp_op;
  logic [2*DATA_W-1:0] r_rsp_data;
  logic                r_alu_begin;
  logic [1:0]          r_alu_op_code;
  logic [DATA_W-1:0]   r_alu_inbus;
  logic                r_busy;

`ifdef ALU_SEQ_TIMEOUT_EN
  logic r_timeout_err;
  logic w_tmo_clear;
  logic w_tmo_enable;
  logic w_tmo_expire;

  // Clearing while in LOAD_B zeroes the count exactly on entry to WAIT_END.
  assign w_tmo_clear  = (r_state == ST_LOAD_B);
  assign w_tmo_enable = (r_state == ST_WAIT_END);

  alu_seq_timeout #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .clear  (w_tmo_clear),
    .enable (w_tmo_enable),
    .expire (w_tmo_expire)
  );

  assign timeout_err = r_timeout_err;
`else
  // TIMEOUT_CYCLES only matters when the timeout option is built in.
  logic w_unused_tmo;
  assign w_unused_tmo = ^TIMEOUT_CYCLES;
`endif

  // All outputs are registered and change together with the state, so each
  // ALU bus value is valid for exactly the cycle of its state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state       <= ST_IDLE;
      r_op          <= '0;
      r_a           <= '0;
      r_b           <= '0;
      r_cmd_ready   <= 1'b1;
      r_rsp_valid   <= 1'b0;
      r_rsp_op      <= '0;
      r_rsp_data    <= '0;
      r_alu_begin   <= 1'b0;
      r_alu_op_code <= '0;
      r_alu_inbus   <= '0;
      r_busy        <= 1'b0;
`ifdef ALU_SEQ_TIMEOUT_EN
      r_timeout_err <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (cmd_valid && r_cmd_ready) begin
            r_op          <= cmd_op;
            r_a           <= cmd_a;
            r_b           <= cmd_b;
            r_cmd_ready   <= 1'b0;
            r_busy        <= 1'b1;
            r_alu_begin   <= 1'b1;
            r_alu_op_code <= cmd_op;
            r_alu_inbus   <= '0;
            r_state       <= ST_ISSUE;
          end
        end

        ST_ISSUE: begin
          r_alu_inbus <= r_a;
          r_state     <= ST_LOAD_A;
        end

        ST_LOAD_A: begin
          r_alu_begin <= 1'b0;
          r_alu_inbus <= r_b;
          r_state     <= ST_LOAD_B;
        end

        ST_LOAD_B: begin
          r_state <= ST_WAIT_END;
        end

        ST_WAIT_END: begin
          if (alu_end) begin
            // hi is zeroed here; two-word ops overwrite it in CAP_HI.
            r_rsp_data <= {{DATA_W{1'b0}}, alu_outbus};
            if (alu_op_words(r_op) == 2'd1) begin
              r_rsp_valid <= 1'b1;
              r_rsp_op    <= r_op;
              r_state     <= ST_RESP;
            end else begin
              r_state <= ST_CAP_HI;
            end
          end
`ifdef ALU_SEQ_TIMEOUT_EN
          else if (w_tmo_expire) begin
            r_rsp_data    <= {(2*DATA_W){1'b1}};
            r_timeout_err <= 1'b1;
            r_rsp_valid   <= 1'b1;
            r_rsp_op      <= r_op;
            r_state       <= ST_RESP;
          end
`endif
        end

        ST_CAP_HI: begin
          // The ALU presents hi in the cycle after END regardless of END's level.
          r_rsp_data[2*DATA_W-1:DATA_W] <= alu_outbus;
          r_rsp_valid                   <= 1'b1;
          r_rsp_op                      <= r_op;
          r_state                       <= ST_RESP;
        end

        ST_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid   <= 1'b0;
            r_cmd_ready   <= 1'b1;
            r_busy        <= 1'b0;
            r_alu_op_code <= '0;
            r_alu_inbus   <= '0;
`ifdef ALU_SEQ_TIMEOUT_EN
            r_timeout_err <= 1'b0;
`endif
            r_state       <= ST_IDLE;
          end
        end

        default: begin
          r_state     <= ST_IDLE;
          r_cmd_ready <= 1'b1;
          r_rsp_valid <= 1'b0;
          r_alu_begin <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready   = r_cmd_ready;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_op      = r_rsp_op;
  assign rsp_data    = r_rsp_data;
  assign alu_begin   = r_alu_begin;
  assign alu_op_code = r_alu_op_code;
  assign alu_inbus   = r_alu_inbus;
  assign busy        = r_busy;

endmodule

`default_nettype wire
